risc_loader: RTL and testbench

RISC_LOADER -- requirements
Module: risc_loader

---
 rtl/risc_loader_if.sv | 25 ++
 rtl/risc_loader.sv | 78 +++++++
 tb/tb_risc_loader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/risc_loader_if.sv
// risc_loader_if: host byte stream, CPU program-memory write port and session status.
interface risc_loader_if;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        cpu_rst;
  logic        halt;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        err;
  logic [15:0] cycle_count;
  modport slave (
    input  start, in_valid, in_data, halt,
    output in_ready, mem_we, mem_addr, mem_data, cpu_rst, busy, done, timeout, err, cycle_count
  );
  modport master (
    output start, in_valid, in_data, halt,
    input  in_ready, mem_we, mem_addr, mem_data, cpu_rst, busy, done, timeout, err, cycle_count
  );
endinterface

// File: rtl/risc_loader.sv
// risc_loader: loads a length-prefixed program into CPU memory, then runs the CPU
// out of reset and measures cycles until halt or timeout.
module risc_loader #(
  parameter int unsigned MAX_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  risc_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HDR, LOAD, CRST, RUN, DONE, TOUT} state_t;
  localparam logic [15:0] LIMIT = 16'(MAX_CYCLES);
  state_t      r_state, w_next;
  logic [5:0]  r_left;
  logic [4:0]  r_addr;
  logic        r_we;
  logic [4:0]  r_waddr;
  logic [7:0]  r_wdata;
  logic        r_err;
  logic [15:0] r_cyc;
  logic        w_acc, w_hdr_ok, w_start, w_tick;
  assign bus.in_ready    = (r_state == HDR) || (r_state == LOAD);
  assign bus.busy        = bus.in_ready || (r_state == CRST) || (r_state == RUN);
  assign bus.cpu_rst     = r_state != RUN;
  assign bus.done        = r_state == DONE;
  assign bus.timeout     = r_state == TOUT;
  assign bus.err         = r_err;
  assign bus.mem_we      = r_we;
  assign bus.mem_addr    = r_waddr;
  assign bus.mem_data    = r_wdata;
  assign bus.cycle_count = r_cyc;
  assign w_acc    = bus.in_valid && bus.in_ready;
  assign w_hdr_ok = (bus.in_data != 8'd0) && (bus.in_data <= 8'd32);
  assign w_start  = bus.start && ((r_state == IDLE) || (r_state == DONE) || (r_state == TOUT));
  assign w_tick   = (r_state == RUN) && !bus.halt;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, TOUT: w_next = bus.start ? HDR : r_state;
      HDR:              w_next = !bus.in_valid ? HDR : w_hdr_ok ? LOAD : IDLE;
      LOAD:             w_next = (bus.in_valid && r_left == 6'd1) ? CRST : LOAD;
      CRST:             w_next = RUN;
      RUN:              w_next = bus.halt ? DONE : (r_cyc + 16'd1 == LIMIT) ? TOUT : RUN;
      default:          w_next = IDLE;
    endcase
  end
  // the write lands one cycle after acceptance, so the last one overlaps CRST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_left  <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_cyc   <= '0;
    end else begin
      r_state <= w_next;
      r_we    <= (r_state == LOAD) && w_acc;
      if ((r_state == LOAD) && w_acc) begin
        r_waddr <= r_addr;
        r_wdata <= bus.in_data;
        r_addr  <= r_addr + 5'd1;
        r_left  <= r_left - 6'd1;
      end
      if ((r_state == HDR) && w_acc) begin
        r_left <= bus.in_data[5:0];
        r_addr <= '0;
        r_err  <= !w_hdr_ok;
      end
      if (w_start) begin
        r_err <= 1'b0;
        r_cyc <= '0;
      end
      if (w_tick) r_cyc <= r_cyc + 16'd1;
    end
  end
endmodule

// File: tb/tb_risc_loader.sv
// tb_risc_loader: directed sessions with a write scoreboard and a halt stub.
module tb_risc_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  risc_loader_if bus();
  risc_loader #(.MAX_CYCLES(20)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct packed {logic [4:0] a; logic [7:0] d;} wr_t;
  wr_t q[$];
  wr_t e;
  int checks = 0;
  int errors = 0;
  int n_wr = 0;
  int edges;
  logic [4:0] exp_addr;
  logic [7:0] prog [32];
  localparam logic [35:0] IDLE_EXP = {2'b00, 5'd0, 8'd0, 1'b1, 4'b0000, 16'd0};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [35:0] idle_obs();
    return {bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_data, bus.cpu_rst,
            bus.busy, bus.done, bus.timeout, bus.err, bus.cycle_count};
  endfunction
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      n_wr++;
      if (q.size() == 0) chk("spurious_we", 1, 0);
      else begin
        e = q.pop_front();
        chk("wr_addr", bus.mem_addr, e.a);
        chk("wr_data", bus.mem_data, e.d);
      end
      chk("we_cpu_rst", bus.cpu_rst, 1);
    end
  end
  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input bit is_prog, input int gap);
    repeat (gap) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 20 && !bus.in_ready; i++) @(negedge clk);
    if (!bus.in_ready) begin
      chk("ready_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    if (is_prog) begin
      q.push_back({exp_addr, b});
      exp_addr++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.in_data = 8'($urandom);
    @(negedge clk);
  endtask
  task automatic load(input int n, input bit rnd);
    do_start();
    exp_addr = '0;
    n_wr = 0;
    send(8'(n), 1'b0, 0);
    for (int i = 0; i < n; i++) send(prog[i], 1'b1, rnd ? int'($urandom_range(0, 3)) : 0);
  endtask
  task automatic run_cpu(input int halt_at, output int n);
    int g = 0;
    n = 0;
    while (bus.cpu_rst && g < 10) begin
      @(negedge clk);
      g++;
    end
    if (bus.cpu_rst) chk("run_entry", 1, 0);
    g = 0;
    while (!bus.cpu_rst && g < 100) begin
      bus.halt = (n >= halt_at);
      @(negedge clk);
      n++;
      g++;
    end
    if (g >= 100) chk("run_budget", g, 0);
    bus.halt = 1'b0;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.halt = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_vals", idle_obs(), IDLE_EXP);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rel", idle_obs(), IDLE_EXP);
    // basic load and run with halt after 11 RUN edges
    prog[0] = 8'hE2; prog[1] = 8'hE2; prog[2] = 8'h00;
    load(3, 1'b0);
    run_cpu(11, edges);
    chk("t1_run_cycles", edges, 12);
    chk("t1_done", bus.done, 1);
    chk("t1_count", bus.cycle_count, 11);
    chk("t1_flags", {bus.busy, bus.timeout, bus.err, bus.cpu_rst}, 4'b0001);
    chk("t1_nwr", n_wr, 3);
    chk("t1_qempty", q.size(), 0);
    // bad headers
    n_wr = 0;
    do_start();
    chk("t2_cleared", {bus.busy, bus.done, bus.in_ready, bus.cycle_count}, {3'b101, 16'd0});
    send(8'd0, 1'b0, 0);
    chk("t2_err0", {bus.err, bus.busy, bus.in_ready, bus.cpu_rst}, 4'b1001);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h55;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    do_start();
    chk("t2_err_clr", bus.err, 0);
    send(8'd33, 1'b0, 0);
    chk("t2_err33", {bus.err, bus.busy, bus.in_ready, bus.cpu_rst}, 4'b1001);
    chk("t2_nwr", n_wr, 0);
    // timeout at MAX_CYCLES
    prog[0] = 8'($urandom); prog[1] = 8'($urandom);
    load(2, 1'b0);
    run_cpu(1000, edges);
    chk("t3_edges", edges, 20);
    chk("t3_tout", {bus.timeout, bus.done, bus.cpu_rst, bus.busy}, 4'b1010);
    chk("t3_count", bus.cycle_count, 20);
    repeat (3) @(negedge clk);
    chk("t3_hold", bus.cycle_count, 20);
    chk("t3_nwr", n_wr, 2);
    // full 32-byte program with random valid gaps
    for (int i = 0; i < 32; i++) prog[i] = 8'($urandom);
    load(32, 1'b1);
    run_cpu(5, edges);
    chk("t4_done", bus.done, 1);
    chk("t4_count", bus.cycle_count, 5);
    chk("t4_nwr", n_wr, 32);
    chk("t4_qempty", q.size(), 0);
    // reset during the 5th LOAD byte
    do_start();
    exp_addr = '0;
    n_wr = 0;
    send(8'd8, 1'b0, 0);
    for (int i = 0; i < 4; i++) send(prog[i], 1'b1, 0);
    bus.in_valid = 1'b1;
    bus.in_data = prog[4];
    #2 rst_n = 1'b0;
    #1 chk("t5_async_rst", idle_obs(), IDLE_EXP);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_stay_idle", {bus.in_ready, bus.busy}, 2'b00);
    bus.in_valid = 1'b0;
    chk("t5_nwr", n_wr, 4);
    chk("t5_qempty", q.size(), 0);
    prog[0] = 8'($urandom);
    load(1, 1'b0);
    run_cpu(3, edges);
    chk("t5_done", bus.done, 1);
    chk("t5_count", bus.cycle_count, 3);
    // start held through the session, halt on first RUN edge
    bus.start = 1'b1;
    @(negedge clk);
    exp_addr = '0;
    n_wr = 0;
    send(8'd1, 1'b0, 0);
    send(prog[1], 1'b1, 0);
    q.push_back(q.pop_front());
    prog[1] = prog[1];
    run_cpu(0, edges);
    chk("t6_edges", edges, 1);
    chk("t6_done", {bus.done, bus.busy}, 2'b10);
    chk("t6_count", bus.cycle_count, 0);
    bus.start = 1'b0;
    @(negedge clk);
    chk("t6_hold_done", bus.done, 1);
    chk("t6_nwr", n_wr, 1);
    do_start();
    chk("t6_restart", {bus.busy, bus.done, bus.in_ready}, 3'b101);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
